// File: rtl/test_sequencer.sv
// test_sequencer
// Harness controller that sequences a DUT through reset, a start delay and a
// set of req/busy/return test channels, then reports the aggregate result.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   start               one-cycle start pulse, honoured only in IDLE or DONE
//   dut_reset           active-high reset pulse to the DUT
//   test_req            per-channel request
//   test_busy           per-channel busy from the DUT
//   test_return         per-channel result, sampled on the first low busy after acceptance
//   running, done       run in progress / run complete
//   pass                all channels returned 1 (valid with done)
//   pass_vec            latched per-channel result
//   timeout_vec         per-channel timeout flag
//   cur_index           active channel in sequential mode, 0 in parallel mode
//   cycle_count         cycles spent in REQ/RUN/NEXT, saturating
//
// state  | meaning
// IDLE   | waiting for start after reset
// RST    | dut_reset held high for RESET_PULSE cycles
// DLY    | START_DELAY cycles of quiet before the first request
// REQ    | at least one active channel still waiting for busy
// RUN    | every active channel accepted, waiting for busy to fall
// NEXT   | sequential only: advance to the next channel or finish
// DONE   | results valid until the next start

module test_sequencer #(
    parameter int NUM_TESTS      = 4,
    parameter int MODE           = 0,
    parameter int RESET_PULSE    = 6,
    parameter int START_DELAY    = 92,
    parameter int TIMEOUT_CYCLES = 200000000,
    parameter int CNT_WIDTH      = 32,
    localparam int IDX_W         = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 dut_reset,
    output logic [NUM_TESTS-1:0] test_req,
    input  logic [NUM_TESTS-1:0] test_busy,
    input  logic [NUM_TESTS-1:0] test_return,
    output logic                 running,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_TESTS-1:0] pass_vec,
    output logic [NUM_TESTS-1:0] timeout_vec,
    output logic [IDX_W-1:0]     cur_index,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_DLY, S_REQ, S_RUN, S_NEXT, S_DONE
    } state_t;

    // Down-counter reload values: the timer expires when it reaches zero.
    localparam logic [CNT_WIDTH-1:0] RST_LOAD = CNT_WIDTH'((RESET_PULSE > 0) ? RESET_PULSE - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] DLY_LOAD = CNT_WIDTH'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] TO_LOAD  = CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_TESTS - 1);

    localparam state_t FIRST_STATE = (RESET_PULSE > 0) ? S_RST :
                                     ((START_DELAY > 0) ? S_DLY : S_REQ);
    localparam state_t END_STATE   = (MODE == 1) ? S_DONE : S_NEXT;

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   tmr;
    logic                   tmr_tc;
    logic [NUM_TESTS-1:0]   acc;          // busy seen high since the request
    logic [NUM_TESTS-1:0]   fin;          // result latched
    logic [NUM_TESTS-1:0]   act;          // channels taking part in the current test slot
    logic [NUM_TESTS-1:0]   accept_now;
    logic [NUM_TESTS-1:0]   complete_now;
    logic                   in_test;
    logic                   all_settled;
    logic                   all_accepted;

    assign in_test      = (state == S_REQ) || (state == S_RUN);
    assign tmr_tc       = (tmr == '0);
    assign accept_now   = test_req & test_busy;
    assign complete_now = in_test ? (act & acc & ~fin & ~test_busy) : '0;
    assign all_settled  = &((fin | complete_now) | ~act);
    assign all_accepted = &((acc | accept_now | fin) | ~act);

    always_comb begin
        act = '0;
        if (MODE == 1) begin
            act = '1;
        end else begin
            act[cur_index] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = FIRST_STATE;
            end
            S_RST: begin
                if (tmr_tc) state_nxt = (START_DELAY > 0) ? S_DLY : S_REQ;
            end
            S_DLY: begin
                if (tmr_tc) state_nxt = S_REQ;
            end
            S_REQ, S_RUN: begin
                // Completion is checked before the timer so a busy falling on
                // the last allowed cycle still counts as finished.
                if (all_settled || tmr_tc) begin
                    state_nxt = END_STATE;
                end else if (all_accepted) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_REQ;
                end
            end
            S_NEXT: begin
                state_nxt = (cur_index == LAST_IDX) ? S_DONE : S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        dut_reset = (state == S_RST);
        running   = (state == S_RST) || (state == S_DLY) || (state == S_REQ) ||
                    (state == S_RUN) || (state == S_NEXT);
        done      = (state == S_DONE);
        pass      = (state == S_DONE) && (&pass_vec);
        test_req  = in_test ? (act & ~acc & ~fin) : '0;
    end

    // Timer, channel flags, results and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr         <= '0;
            acc         <= '0;
            fin         <= '0;
            pass_vec    <= '0;
            timeout_vec <= '0;
            cur_index   <= '0;
            cycle_count <= '0;
        end else begin
            // Entering REQ from NEXT reloads the timer, giving each
            // sequential test its own timeout window; REQ->RUN keeps counting.
            if (state_nxt != state && state_nxt == S_RST) begin
                tmr <= RST_LOAD;
            end else if (state_nxt != state && state_nxt == S_DLY) begin
                tmr <= DLY_LOAD;
            end else if (state_nxt != state && state_nxt == S_REQ) begin
                tmr <= TO_LOAD;
            end else if ((state == S_RST || state == S_DLY || in_test) && !tmr_tc) begin
                tmr <= tmr - 1'b1;
            end

            if ((state == S_IDLE || state == S_DONE) && start) begin
                acc         <= '0;
                fin         <= '0;
                pass_vec    <= '0;
                timeout_vec <= '0;
                cur_index   <= '0;
                cycle_count <= '0;
            end else begin
                if (in_test) begin
                    acc      <= acc | accept_now;
                    fin      <= fin | complete_now;
                    pass_vec <= (pass_vec & ~complete_now) | (test_return & complete_now);
                    if (!all_settled && tmr_tc) begin
                        timeout_vec <= timeout_vec | (act & ~(fin | complete_now));
                    end
                end
                if (state == S_NEXT && cur_index != LAST_IDX) begin
                    cur_index <= cur_index + 1'b1;
                end
                if ((in_test || state == S_NEXT) && cycle_count != '1) begin
                    cycle_count <= cycle_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;

    localparam int N = 4;

    typedef struct packed {
        logic [3:0] pv;
        logic [3:0] tv;
        logic       ps;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- sequential instance ----------------
    logic         s_rst, s_start, s_dut_reset, s_running, s_done, s_pass;
    logic [N-1:0] s_req, s_busy, s_ret, s_pv, s_tv;
    logic [1:0]   s_idx;
    logic [31:0]  s_cc;

    test_sequencer #(
        .NUM_TESTS(N), .MODE(0), .RESET_PULSE(6), .START_DELAY(92),
        .TIMEOUT_CYCLES(100), .CNT_WIDTH(32)
    ) u_seq (
        .clk(clk), .reset(s_rst), .start(s_start), .dut_reset(s_dut_reset),
        .test_req(s_req), .test_busy(s_busy), .test_return(s_ret),
        .running(s_running), .done(s_done), .pass(s_pass),
        .pass_vec(s_pv), .timeout_vec(s_tv), .cur_index(s_idx), .cycle_count(s_cc)
    );

    // ---------------- parallel instance ----------------
    logic         p_rst, p_start, p_dut_reset, p_running, p_done, p_pass;
    logic [N-1:0] p_req, p_busy, p_ret, p_pv, p_tv;
    logic [1:0]   p_idx;
    logic [31:0]  p_cc;

    test_sequencer #(
        .NUM_TESTS(N), .MODE(1), .RESET_PULSE(2), .START_DELAY(3),
        .TIMEOUT_CYCLES(100), .CNT_WIDTH(32)
    ) u_par (
        .clk(clk), .reset(p_rst), .start(p_start), .dut_reset(p_dut_reset),
        .test_req(p_req), .test_busy(p_busy), .test_return(p_ret),
        .running(p_running), .done(p_done), .pass(p_pass),
        .pass_vec(p_pv), .timeout_vec(p_tv), .cur_index(p_idx), .cycle_count(p_cc)
    );

    // DUT model configuration (written only by the stimulus thread)
    int           s_len[N], s_rise[N];
    logic [N-1:0] s_rv, s_never;
    int           p_len[N], p_rise[N];
    logic [N-1:0] p_rv, p_never;

    exp_t sb_s[$];
    exp_t sb_p[$];
    int   ord_s[$];

    // ---------------- sequential monitor + DUT model ----------------
    int           s_w[N], s_cnt[N], s_req_hi[N];
    int           s_rst_hi, s_t_fall, s_t_req;
    logic         s_prev_rst = 1'b0, s_prev_done = 1'b0;
    logic [N-1:0] s_prev_req = '0;

    always @(negedge clk) begin
        exp_t e;
        if (s_start && !s_running) begin
            s_rst_hi = 0; s_t_fall = -1; s_t_req = -1;
            for (int i = 0; i < N; i++) s_req_hi[i] = 0;
        end
        if (s_dut_reset) s_rst_hi++;
        if (s_prev_rst && !s_dut_reset) s_t_fall = cyc;
        for (int i = 0; i < N; i++) begin
            if (s_req[i]) s_req_hi[i]++;
            if (s_req[i] && !s_prev_req[i]) begin
                if (s_t_req < 0) s_t_req = cyc;
                chk("seq_req_onehot", $countones(s_req), 1);
                chk("seq_idx", s_idx, i);
                if (ord_s.size() == 0) chk("seq_req_unexpected", i, 99);
                else chk("seq_req_order", i, ord_s.pop_front());
            end
        end
        if (s_done && !s_prev_done) begin
            if (sb_s.size() == 0) begin
                chk("seq_done_unexpected", s_done, 0);
            end else begin
                e = sb_s.pop_front();
                chk("seq_pass_vec", s_pv, e.pv);
                chk("seq_timeout_vec", s_tv, e.tv);
                chk("seq_pass", s_pass, e.ps);
                chk("seq_running_at_done", s_running, 0);
                chk("seq_rst_width", s_rst_hi, 6);
                chk("seq_start_delay", s_t_req - s_t_fall, 92);
                chk("seq_cycle_count", s_cc, cyc - s_t_req);
            end
        end
        s_prev_rst  = s_dut_reset;
        s_prev_req  = s_req;
        s_prev_done = s_done;

        for (int i = 0; i < N; i++) begin
            if (s_rst) begin
                s_busy[i] = 1'b0; s_w[i] = 0;
            end else if (s_busy[i]) begin
                s_cnt[i]--;
                if (s_cnt[i] == 0) begin
                    s_busy[i] = 1'b0;
                    s_ret[i]  = s_rv[i];
                end
            end else if (s_req[i] && !s_never[i]) begin
                if (s_w[i] == s_rise[i]) begin
                    s_busy[i] = 1'b1; s_cnt[i] = s_len[i];
                    s_ret[i]  = ~s_rv[i];
                    s_w[i]    = 0;
                end else begin
                    s_w[i]++;
                end
            end else begin
                s_w[i] = 0;
            end
        end
    end

    // ---------------- parallel monitor + DUT model ----------------
    int           p_w[N], p_cnt[N];
    int           p_t_req, p_last_fall;
    logic         p_prev_done = 1'b0;
    logic [N-1:0] p_prev_req = '0;

    always @(negedge clk) begin
        exp_t e;
        if (p_start && !p_running) begin
            p_t_req = -1; p_last_fall = -1;
        end
        if (p_req != '0 && p_prev_req == '0 && p_t_req < 0) begin
            p_t_req = cyc;
            chk("par_req_all", p_req, 4'hF);
            chk("par_idx", p_idx, 0);
        end
        if (p_done && !p_prev_done) begin
            if (sb_p.size() == 0) begin
                chk("par_done_unexpected", p_done, 0);
            end else begin
                e = sb_p.pop_front();
                chk("par_pass_vec", p_pv, e.pv);
                chk("par_timeout_vec", p_tv, e.tv);
                chk("par_pass", p_pass, e.ps);
                if (e.tv == '0) chk("par_done_latency", cyc - p_last_fall, 1);
                else chk("par_timeout_latency", cyc - p_t_req, 100);
            end
        end
        p_prev_req  = p_req;
        p_prev_done = p_done;

        for (int i = 0; i < N; i++) begin
            if (p_rst) begin
                p_busy[i] = 1'b0; p_w[i] = 0;
            end else if (p_busy[i]) begin
                p_cnt[i]--;
                if (p_cnt[i] == 0) begin
                    p_busy[i]   = 1'b0;
                    p_ret[i]    = p_rv[i];
                    p_last_fall = cyc;
                end
            end else if (p_req[i] && !p_never[i]) begin
                if (p_w[i] == p_rise[i]) begin
                    p_busy[i] = 1'b1; p_cnt[i] = p_len[i];
                    p_ret[i]  = ~p_rv[i];
                    p_w[i]    = 0;
                end else begin
                    p_w[i]++;
                end
            end else begin
                p_w[i] = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cfg_s(input int l0, input int l1, input int l2, input int l3,
                         input logic [3:0] rv, input logic [3:0] nev);
        s_len = '{l0, l1, l2, l3};
        s_rv = rv; s_never = nev;
    endtask

    task automatic cfg_p(input int l0, input int l1, input int l2, input int l3,
                         input logic [3:0] rv, input logic [3:0] nev);
        p_len = '{l0, l1, l2, l3};
        p_rv = rv; p_never = nev;
    endtask

    task automatic run_s(input logic [3:0] pv, input logic [3:0] tv, input int restart_at);
        exp_t e;
        int k;
        e.pv = pv; e.tv = tv; e.ps = &pv;
        sb_s.push_back(e);
        for (int i = 0; i < N; i++) ord_s.push_back(i);
        @(posedge clk); #2 s_start = 1'b1;
        @(posedge clk); #2 s_start = 1'b0;
        if (restart_at > 0) begin
            repeat (restart_at) @(posedge clk);
            #2 s_start = 1'b1;
            @(posedge clk); #2 s_start = 1'b0;
        end
        k = 0;
        while (!s_done && k < 2000) begin @(posedge clk); k++; end
        chk("seq_wait_done", s_done, 1);
        @(negedge clk); @(negedge clk);
    endtask

    task automatic run_p(input logic [3:0] pv, input logic [3:0] tv);
        exp_t e;
        int k;
        e.pv = pv; e.tv = tv; e.ps = &pv;
        sb_p.push_back(e);
        @(posedge clk); #2 p_start = 1'b1;
        @(posedge clk); #2 p_start = 1'b0;
        k = 0;
        while (!p_done && k < 1000) begin @(posedge clk); k++; end
        chk("par_wait_done", p_done, 1);
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        int k;
        int la, lb, lc;
        s_rst = 1'b1; s_start = 1'b0; s_busy = '0; s_ret = '0;
        p_rst = 1'b1; p_start = 1'b0; p_busy = '0; p_ret = '0;
        s_rise = '{1, 3, 1, 2};
        p_rise = '{1, 1, 1, 1};
        cfg_s(1, 1, 1, 1, '0, '0);
        cfg_p(1, 1, 1, 1, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        chk("seq_reset_outs", {s_dut_reset, s_req, s_running, s_done, s_pass, s_pv, s_tv, s_idx}, 0);
        chk("seq_reset_cc", s_cc, 0);
        chk("par_reset_outs", {p_dut_reset, p_req, p_running, p_done, p_pass, p_pv, p_tv, p_idx}, 0);
        @(posedge clk); #2 s_rst = 1'b0; p_rst = 1'b0;

        // mixed returns, random busy lengths
        la = $urandom_range(50, 1); lb = $urandom_range(50, 1); lc = $urandom_range(50, 1);
        cfg_s(20, la, lb, lc, 4'b1011, 4'b0000);
        run_s(4'b1011, 4'b0000, 0);

        // all pass
        cfg_s(20, 5, $urandom_range(50, 1), 1, 4'b1111, 4'b0000);
        run_s(4'b1111, 4'b0000, 0);

        // channel 2 never answers; a start during DLY must be ignored
        cfg_s($urandom_range(50, 1), $urandom_range(50, 1), 5, $urandom_range(50, 1), 4'b1111, 4'b0100);
        run_s(4'b1011, 4'b0100, 20);
        chk("seq_req2_high_cycles", s_req_hi[2], 100);

        // channel 1 falls on the timeout cycle, channel 3 one cycle too late
        cfg_s(10, 96, 7, 98, 4'b1111, 4'b0000);
        run_s(4'b0111, 4'b1000, 0);

        // abort in RUN, then rerun the first configuration
        cfg_s(20, la, lb, lc, 4'b1011, 4'b0000);
        ord_s.push_back(0);
        @(posedge clk); #2 s_start = 1'b1;
        @(posedge clk); #2 s_start = 1'b0;
        k = 0;
        while (!s_busy[0] && k < 500) begin @(posedge clk); k++; end
        repeat (3) @(posedge clk);
        chk("abort_in_run", s_busy[0], 1);
        #2 s_rst = 1'b1;
        #1;
        chk("abort_req", s_req, 0);
        chk("abort_dut_reset", s_dut_reset, 0);
        chk("abort_done", s_done, 0);
        chk("abort_running", s_running, 0);
        @(posedge clk); #2 s_rst = 1'b0;
        @(negedge clk);
        run_s(4'b1011, 4'b0000, 0);

        // parallel: two channels finish together, last one at 30
        cfg_p(5, 5, 30, 12, 4'b1111, 4'b0000);
        run_p(4'b1111, 4'b0000);

        // parallel: channel 3 never answers, mixed returns
        cfg_p(3, 40, 8, 5, 4'b0101, 4'b1000);
        run_p(4'b0101, 4'b1000);

        // parallel: channel 2 finishes on the timeout cycle
        cfg_p(4, 10, 98, 20, 4'b1111, 4'b0000);
        run_p(4'b1111, 4'b0000);

        chk("scoreboard_drained", sb_s.size() + sb_p.size() + ord_s.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
